// File: rtl/beep_tone_sched.sv
// rtl/beep_tone_sched.sv - buzzer divider scheduler shared by IR keys and a melody player
// Build option: BEEP_SCHED_LOOP_EN makes the melody wrap to entry 0 until PLAY_STOP.
module beep_tone_sched #(
  parameter int TICK_DIV     = 50000,
  parameter int KEY_HOLD_MS  = 200,
  parameter int NOTE_UNIT_MS = 125,
  parameter int GAP_MS       = 20
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic [7:0]  KEY_CODE,
  input  logic        KEY_VALID,
  input  logic        PLAY_START,
  input  logic        PLAY_STOP,
  output logic [15:0] FREQ_DIV,
  output logic        TONE_EN,
  output logic        SRC_MEL,
  output logic [2:0]  NOTE_IDX,
  output logic        BUSY,
  output logic        DONE
);

`ifdef BEEP_SCHED_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, KEY_TONE, MEL_NOTE, MEL_GAP} state_t;

  state_t      state;
  logic [15:0] tick_cnt;
  logic [15:0] ms_cnt;
  logic        resume;

  function automatic logic [3:0] key_tone_idx(input logic [7:0] code);
    case (code)
      8'h0C:   return 4'd1;
      8'h18:   return 4'd2;
      8'h5E:   return 4'd3;
      8'h08:   return 4'd4;
      8'h1C:   return 4'd5;
      8'h5A:   return 4'd6;
      8'h42:   return 4'd7;
      8'h52:   return 4'd8;
      8'h4A:   return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [15:0] tone_div(input logic [3:0] idx);
    case (idx)
      4'd1:    return 16'd47774;
      4'd2:    return 16'd42568;
      4'd3:    return 16'd37919;
      4'd4:    return 16'd35791;
      4'd5:    return 16'd31888;
      4'd6:    return 16'd28409;
      4'd7:    return 16'd25309;
      4'd8:    return 16'd23889;
      4'd9:    return 16'd21276;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [3:0] rom_tone(input logic [2:0] e);
    case (e)
      3'd0:    return 4'd1;
      3'd1:    return 4'd2;
      3'd2:    return 4'd3;
      3'd3:    return 4'd1;
      3'd4:    return 4'd5;
      3'd5:    return 4'd0;
      3'd6:    return 4'd5;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [2:0] rom_len(input logic [2:0] e);
    case (e)
      3'd4, 3'd6, 3'd7: return 3'd4;
      default:          return 3'd2;
    endcase
  endfunction

  logic [3:0]  key_idx;
  logic        key_tone;
  logic        key_rest;
  logic        start;
  logic        resume_eff;
  logic        resume_pre;
  logic [2:0]  mel_tgt;
  logic [15:0] mel_div;
  logic [15:0] key_div;
  logic [15:0] dur_ms;
  logic        expire;

  always_comb begin
    key_idx  = key_tone_idx(KEY_CODE);
    key_tone = KEY_VALID && (key_idx != 4'd0);
    key_rest = KEY_VALID && (KEY_CODE == 8'h16);
    key_div  = tone_div(key_idx);
    // PLAY_STOP dominates PLAY_START in the same cycle
    start      = PLAY_START && !PLAY_STOP;
    resume_eff = PLAY_STOP ? 1'b0 : (start ? 1'b1 : resume);
    // A key in the last gap of a one-shot melody leaves nothing to resume
    resume_pre = start || LOOP_EN || !(state == MEL_GAP && NOTE_IDX == 3'd7);
    mel_tgt  = start ? 3'd0 : ((state == MEL_GAP) ? NOTE_IDX + 3'd1 : NOTE_IDX);
    mel_div  = tone_div(rom_tone(mel_tgt));
    case (state)
      KEY_TONE: dur_ms = 16'(KEY_HOLD_MS);
      MEL_NOTE: dur_ms = 16'(rom_len(NOTE_IDX)) * 16'(NOTE_UNIT_MS);
      MEL_GAP:  dur_ms = 16'(GAP_MS);
      default:  dur_ms = 16'd0;
    endcase
    expire = (tick_cnt == TICK_LAST) && (ms_cnt == dur_ms - 16'd1);
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      tick_cnt <= 16'd0;
      ms_cnt   <= 16'd0;
      resume   <= 1'b0;
      FREQ_DIV <= 16'd0;
      TONE_EN  <= 1'b0;
      SRC_MEL  <= 1'b0;
      NOTE_IDX <= 3'd0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= 16'd0;
        ms_cnt   <= ms_cnt + 16'd1;
      end else begin
        tick_cnt <= tick_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          tick_cnt <= 16'd0;
          ms_cnt   <= 16'd0;
          if (key_tone) begin
            state    <= KEY_TONE;
            FREQ_DIV <= key_div;
            TONE_EN  <= 1'b1;
            SRC_MEL  <= 1'b0;
            BUSY     <= 1'b1;
            if (start) begin
              resume   <= 1'b1;
              NOTE_IDX <= 3'd0;
            end
          end else if (start) begin
            state    <= MEL_NOTE;
            NOTE_IDX <= 3'd0;
            FREQ_DIV <= mel_div;
            TONE_EN  <= (mel_div != 16'd0);
            SRC_MEL  <= 1'b1;
            BUSY     <= 1'b1;
          end
        end

        KEY_TONE: begin
          resume <= resume_eff;
          if (PLAY_STOP || start) NOTE_IDX <= 3'd0;
          if (key_tone) begin
            FREQ_DIV <= key_div;
            tick_cnt <= 16'd0;
            ms_cnt   <= 16'd0;
          end else if (key_rest || expire) begin
            tick_cnt <= 16'd0;
            ms_cnt   <= 16'd0;
            if (resume_eff) begin
              state    <= MEL_NOTE;
              resume   <= 1'b0;
              NOTE_IDX <= mel_tgt;
              FREQ_DIV <= mel_div;
              TONE_EN  <= (mel_div != 16'd0);
              SRC_MEL  <= 1'b1;
            end else begin
              state    <= IDLE;
              FREQ_DIV <= 16'd0;
              TONE_EN  <= 1'b0;
              SRC_MEL  <= 1'b0;
              BUSY     <= 1'b0;
            end
          end
        end

        default: begin
          if (PLAY_STOP) begin
            state    <= IDLE;
            NOTE_IDX <= 3'd0;
            FREQ_DIV <= 16'd0;
            TONE_EN  <= 1'b0;
            SRC_MEL  <= 1'b0;
            BUSY     <= 1'b0;
            tick_cnt <= 16'd0;
            ms_cnt   <= 16'd0;
          end else if (key_tone) begin
            state    <= KEY_TONE;
            resume   <= resume_pre;
            NOTE_IDX <= mel_tgt;
            FREQ_DIV <= key_div;
            TONE_EN  <= 1'b1;
            SRC_MEL  <= 1'b0;
            tick_cnt <= 16'd0;
            ms_cnt   <= 16'd0;
          end else if (start || (expire && state == MEL_GAP)) begin
            tick_cnt <= 16'd0;
            ms_cnt   <= 16'd0;
            if (!start && NOTE_IDX == 3'd7) begin
              DONE     <= 1'b1;
              NOTE_IDX <= 3'd0;
            end
            if (!start && NOTE_IDX == 3'd7 && !LOOP_EN) begin
              state    <= IDLE;
              FREQ_DIV <= 16'd0;
              TONE_EN  <= 1'b0;
              SRC_MEL  <= 1'b0;
              BUSY     <= 1'b0;
            end else begin
              state    <= MEL_NOTE;
              NOTE_IDX <= mel_tgt;
              FREQ_DIV <= mel_div;
              TONE_EN  <= (mel_div != 16'd0);
            end
          end else if (expire) begin
            state    <= MEL_GAP;
            FREQ_DIV <= 16'd0;
            TONE_EN  <= 1'b0;
            tick_cnt <= 16'd0;
            ms_cnt   <= 16'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beep_tone_sched.sv
// tb/tb_beep_tone_sched.sv - scoreboard bench for beep_tone_sched
module tb_beep_tone_sched;

  logic        CLK_50M = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  KEY_CODE = 8'h00;
  logic        KEY_VALID = 1'b0;
  logic        PLAY_START = 1'b0;
  logic        PLAY_STOP = 1'b0;
  logic [15:0] FREQ_DIV;
  logic        TONE_EN;
  logic        SRC_MEL;
  logic [2:0]  NOTE_IDX;
  logic        BUSY;
  logic        DONE;

  beep_tone_sched #(.TICK_DIV(10), .KEY_HOLD_MS(5), .NOTE_UNIT_MS(4), .GAP_MS(2)) dut (
    .CLK_50M(CLK_50M), .RST_N(RST_N), .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID),
    .PLAY_START(PLAY_START), .PLAY_STOP(PLAY_STOP), .FREQ_DIV(FREQ_DIV), .TONE_EN(TONE_EN),
    .SRC_MEL(SRC_MEL), .NOTE_IDX(NOTE_IDX), .BUSY(BUSY), .DONE(DONE)
  );

  always #10 CLK_50M = ~CLK_50M;

  typedef struct {
    int div; int ten; int src; int busy; int idx; int done; int len;
  } seg_t;

  seg_t sq[$];
  int total = 0;
  int bad = 0;
  int seg_n = 0;
  int done_cnt = 0;
  int base_done;

  int mel_tone[8] = '{1, 2, 3, 1, 5, 0, 5, 8};
  int mel_len[8]  = '{2, 2, 2, 2, 4, 2, 4, 4};
  int divs[10]    = '{0, 47774, 42568, 37919, 35791, 31888, 28409, 25309, 23889, 21276};

  always @(negedge CLK_50M) if (DONE) done_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_seg(input int div, ten, src, busy, idx, done, len);
    seg_t s;
    s.div = div; s.ten = ten; s.src = src; s.busy = busy; s.idx = idx; s.done = done; s.len = len;
    sq.push_back(s);
  endtask

  task automatic push_note(input int e);
    push_seg(divs[mel_tone[e]], (mel_tone[e] != 0) ? 1 : 0, 1, 1, e, 0, mel_len[e] * 40);
    push_seg(0, 0, 1, 1, e, 0, 20);
  endtask

  task automatic push_tail();
`ifdef BEEP_SCHED_LOOP_EN
    push_seg(47774, 1, 1, 1, 0, 1, 1);
`else
    push_seg(0, 0, 0, 0, 0, 1, 1);
`endif
  endtask

  task automatic pulse(input logic kv, input logic [7:0] code, input logic st, input logic sp);
    KEY_VALID = kv; KEY_CODE = code; PLAY_START = st; PLAY_STOP = sp;
    @(negedge CLK_50M);
    KEY_VALID = 1'b0; PLAY_START = 1'b0; PLAY_STOP = 1'b0;
  endtask

  task automatic run_segs();
    seg_t s;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      chk($sformatf("seg%0d.div", seg_n), int'(FREQ_DIV), s.div);
      chk($sformatf("seg%0d.ten", seg_n), int'(TONE_EN), s.ten);
      chk($sformatf("seg%0d.src", seg_n), int'(SRC_MEL), s.src);
      chk($sformatf("seg%0d.busy", seg_n), int'(BUSY), s.busy);
      chk($sformatf("seg%0d.idx", seg_n), int'(NOTE_IDX), s.idx);
      chk($sformatf("seg%0d.done", seg_n), int'(DONE), s.done);
      repeat (s.len - 1) @(negedge CLK_50M);
      chk($sformatf("seg%0d.div_end", seg_n), int'(FREQ_DIV), s.div);
      chk($sformatf("seg%0d.busy_end", seg_n), int'(BUSY), s.busy);
      @(negedge CLK_50M);
      seg_n++;
    end
  endtask

  task automatic finish_mel(input string tag);
`ifdef BEEP_SCHED_LOOP_EN
    pulse(1'b0, 8'h00, 1'b0, 1'b1);
`endif
    chk({tag, ".busy"}, int'(BUSY), 0);
    chk({tag, ".idx"}, int'(NOTE_IDX), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".div"}, int'(FREQ_DIV), 0);
    chk({tag, ".ten"}, int'(TONE_EN), 0);
    chk({tag, ".src"}, int'(SRC_MEL), 0);
    chk({tag, ".busy"}, int'(BUSY), 0);
    chk({tag, ".idx"}, int'(NOTE_IDX), 0);
    chk({tag, ".done"}, int'(DONE), 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK_50M);
    chk_idle("rst");
    RST_N = 1'b1;
    @(negedge CLK_50M);

    // reset mid-tone clears outputs without waiting for a clock edge
    pulse(1'b1, 8'h1C, 1'b0, 1'b0);
    repeat (10) @(negedge CLK_50M);
    chk("pre_rst.div", int'(FREQ_DIV), 31888);
    #2 RST_N = 1'b0;
    #1 chk_idle("async_rst");
    @(negedge CLK_50M);
    RST_N = 1'b1;
    @(negedge CLK_50M);
    chk_idle("post_rst");

    // single key tone
    push_seg(31888, 1, 0, 1, 0, 0, 50);
    push_seg(0, 0, 0, 0, 0, 0, 1);
    pulse(1'b1, 8'h1C, 1'b0, 1'b0);
    run_segs();

    // full melody pass
    base_done = done_cnt;
    for (int e = 0; e < 8; e++) push_note(e);
    push_tail();
    pulse(1'b0, 8'h00, 1'b1, 1'b0);
    run_segs();
    finish_mel("mel");
    chk("mel.done_cnt", done_cnt - base_done, 1);

    // key preempts entry 4; entry 4 restarts in full afterwards
    for (int e = 0; e < 4; e++) push_note(e);
    pulse(1'b0, 8'h00, 1'b1, 1'b0);
    run_segs();
    chk("e4.div", int'(FREQ_DIV), 31888);
    repeat (30) @(negedge CLK_50M);
    push_seg(21276, 1, 0, 1, 4, 0, 50);
    for (int e = 4; e < 8; e++) push_note(e);
    push_tail();
    pulse(1'b1, 8'h4A, 1'b0, 1'b0);
    run_segs();
    finish_mel("pre");

    // rest key ends a key tone at once
    pulse(1'b1, 8'h0C, 1'b0, 1'b0);
    chk("k0c.div", int'(FREQ_DIV), 47774);
    repeat (19) @(negedge CLK_50M);
    chk("k0c.div_late", int'(FREQ_DIV), 47774);
    pulse(1'b1, 8'h16, 1'b0, 1'b0);
    chk_idle("rest_key");

    // unknown code and rest key in IDLE are ignored
    pulse(1'b1, 8'h33, 1'b0, 1'b0);
    chk_idle("unk_key");
    pulse(1'b1, 8'h16, 1'b0, 1'b0);
    chk_idle("rest_idle");

    // stop beats start
    pulse(1'b0, 8'h00, 1'b1, 1'b1);
    chk_idle("start_stop");

    // key with start: key first, then melody from entry 0; stop aborts
    push_seg(35791, 1, 0, 1, 0, 0, 50);
    push_seg(47774, 1, 1, 1, 0, 0, 80);
    pulse(1'b1, 8'h08, 1'b1, 1'b0);
    run_segs();
    chk("ks.gap_src", int'(SRC_MEL), 1);
    pulse(1'b0, 8'h00, 1'b0, 1'b1);
    chk_idle("ks_stop");

    // stop during a preempting key tone drops the resume
    pulse(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (5) @(negedge CLK_50M);
    pulse(1'b1, 8'h5E, 1'b0, 1'b0);
    pulse(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ksp.div", int'(FREQ_DIV), 37919);
    chk("ksp.src", int'(SRC_MEL), 0);
    repeat (48) @(negedge CLK_50M);
    chk("ksp.div_last", int'(FREQ_DIV), 37919);
    @(negedge CLK_50M);
    chk_idle("ksp_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/beep_tone_sched.md
Name: beep_tone_sched

Overview:
- Tone scheduler that owns the buzzer tone generator's divider input and shares it between two requesters: IR key presses and a built-in melody player.
- Outputs a half-period divider value (50 MHz / (2·f)) plus an enable.
- Key requests preempt the melody. A preempted melody resumes from the start of the interrupted note.
- Sits between the IR decoder and the buzzer tone generator.

Parameters:
- TICK_DIV, 50000, CLK_50M cycles per 1 ms tick.
- KEY_HOLD_MS, 200, duration of a key-triggered tone in ms.
- NOTE_UNIT_MS, 125, ms per melody length unit.
- GAP_MS, 20, silent gap after each melody note in ms.

Ports:
- CLK_50M  in  1  system clock, 50 MHz
- RST_N  in  1  asynchronous active-low reset
- KEY_CODE  in  8  IR key code, sampled when KEY_VALID=1
- KEY_VALID  in  1  one-cycle strobe, new key code
- PLAY_START  in  1  one-cycle strobe, start melody from entry 0
- PLAY_STOP  in  1  one-cycle strobe, abort melody
- FREQ_DIV  out  16  divider to tone generator; 0 = silent
- TONE_EN  out  1  1 while a non-rest tone is driven
- SRC_MEL  out  1  1 while the melody owns the generator (MEL_NOTE or MEL_GAP)
- NOTE_IDX  out  3  current or saved melody entry
- BUSY  out  1  1 in any state other than IDLE
- DONE  out  1  one-cycle pulse when the melody completes its last entry

Behaviour:
- Reset: all outputs 0, state IDLE, resume flag 0, ms counters 0.
- Registering: all outputs are registered. FREQ_DIV and TONE_EN change exactly 1 cycle after the triggering strobe or timer expiry.
- Timing base: the ms prescaler and the duration counter both clear on every state transition, so every duration is exact to the cycle. A duration of N ms = N·TICK_DIV cycles.
- Key map, tone index, then divider:
  - 0x0C: index 1, 47774
  - 0x18: index 2, 42568
  - 0x5E: index 3, 37919
  - 0x08: index 4, 35791
  - 0x1C: index 5, 31888
  - 0x5A: index 6, 28409
  - 0x42: index 7, 25309
  - 0x52: index 8, 23889
  - 0x4A: index 9, 21276
  - 0x16: rest (index 0)
  - Any other code is ignored, with no state change.
- Melody ROM, 8 entries of {tone index, length units}: (1,2) (2,2) (3,2) (1,2) (5,4) (0,2) (5,4) (8,4). Tone index 0 = rest: FREQ_DIV=0, TONE_EN=0, duration still counted.
- States:
  - IDLE: FREQ_DIV=0, TONE_EN=0.
    - KEY_VALID with a tone code → KEY_TONE.
    - PLAY_START → MEL_NOTE with NOTE_IDX=0.
  - KEY_TONE: drives the key divider for KEY_HOLD_MS.
    - A new valid tone key retriggers: the divider updates and the hold timer restarts.
    - Key 0x16 ends the tone immediately.
    - On end: if the resume flag is set → MEL_NOTE at the saved NOTE_IDX, resume flag cleared; otherwise → IDLE.
  - MEL_NOTE: drives the ROM divider for length·NOTE_UNIT_MS, then → MEL_GAP.
    - A valid tone key preempts: resume flag set, NOTE_IDX held, → KEY_TONE.
  - MEL_GAP: silent for GAP_MS.
    - If NOTE_IDX < 7: NOTE_IDX+1 → MEL_NOTE.
    - If NOTE_IDX = 7: DONE pulse and NOTE_IDX cleared to 0; then → IDLE, or → MEL_NOTE when looping (see Optional Feature).
    - A key press during MEL_GAP preempts; the saved NOTE_IDX is the next entry.
- Simultaneous events and corner cases:
  - PLAY_STOP wins over PLAY_START in the same cycle.
  - PLAY_STOP in a melody state → IDLE, NOTE_IDX=0.
  - PLAY_STOP in KEY_TONE clears the resume flag; the key tone continues.
  - PLAY_START in KEY_TONE sets the resume flag with saved NOTE_IDX=0.
  - KEY_VALID together with PLAY_START in IDLE: the key is served first, and the melody starts at entry 0 after the key tone.
  - PLAY_START during a melody restarts at entry 0.
  - Key 0x16 outside KEY_TONE is ignored.
  - Reset asserted mid-note forces the reset values immediately (asynchronous).

Optional Feature:
- Macro: BEEP_SCHED_LOOP_EN.
- Defined: after entry 7's gap the melody wraps to entry 0 and continues until PLAY_STOP. DONE still pulses at each wrap, and BUSY stays 1.
- Undefined: the melody plays once, then goes to IDLE.

Test Plan (bench uses TICK_DIV=10, KEY_HOLD_MS=5, NOTE_UNIT_MS=4, GAP_MS=2):
- Reset mid-tone → all outputs 0 in the same cycle; after release, IDLE.
- KEY 0x1C strobe in IDLE → next cycle FREQ_DIV=31888, TONE_EN=1, BUSY=1; 50 cycles later FREQ_DIV=0, BUSY=0.
- PLAY_START → entry 0 at 47774 for 80 cycles, 20 cycles silent, entry 1 at 42568. The full pass takes the note lengths plus 8 gaps; DONE pulses once, then IDLE (LOOP_EN undefined).
- KEY 0x4A during entry 4 → 21276 for 50 cycles, then entry 4 (31888) restarts with the full 160 cycles, SRC_MEL=1.
- KEY 0x0C, then 0x16 after 20 cycles → silent next cycle, IDLE. Unknown code 0x33 → no change.
- PLAY_START and PLAY_STOP in the same cycle → remains IDLE. With LOOP_EN defined, after entry 7 NOTE_IDX=0, DONE=1 and playback continues.
